peripheral_io_responder: RTL
============================

// Module: peripheral_io_responder
// PURPOSE
//  Device end of RISC_V_Core's to_peripheral/from_peripheral I/O port. Decodes core commands:
//  WRITE pushes a word into a TX FIFO drained by a host/console stream; READ pops from an RX
//  FIFO filled by the host; STATUS returns occupancy and error flags. Responses go back on
//  from_peripheral* one cycle after each command. Sits beside the core in SoC top and benches.
// PARAMETERS
//  DATA_WIDTH  32  width of core data, FIFO words and host streams
//  FIFO_DEPTH  8   entries per FIFO; power of two, 2..128
// PORTS
//  clock                  in   1           system clock, all logic on rising edge
//  reset                  in   1           asynchronous, active-low reset
//  to_peripheral          in   2           core command: 00 NOP, 01 WRITE, 10 READ, 11 STATUS
//  to_peripheral_data     in   DATA_WIDTH  WRITE payload (ignored for other commands)
//  to_peripheral_valid    in   1           command qualifier, one cycle per command
//  from_peripheral        out  2           response: 00 none, 01 OK, 10 EMPTY, 11 FULL_ERR
//  from_peripheral_data   out  DATA_WIDTH  response payload
//  from_peripheral_valid  out  1           one-cycle response pulse
//  out_data               out  DATA_WIDTH  TX FIFO head toward host
//  out_valid              out  1           TX FIFO non-empty
//  out_ready              in   1           host accepts out_data when out_valid&out_ready
//  host_data              in   DATA_WIDTH  word from host into RX FIFO
//  host_valid             in   1           host word present
//  host_ready             out  1           RX FIFO not full
// BEHAVIOUR
//  - Reset (reset==0, async): both FIFOs emptied (pointers/counts 0), tx_overflow=0,
//    from_peripheral=2'b00, from_peripheral_data=0, from_peripheral_valid=0, out_valid=0,
//    out_data=0, host_ready=0 while reset asserted, 1 from first cycle after release.
//  - Reset mid-operation discards all FIFO contents and any pending response; no pulse after.
//  - Core has no backpressure: every valid command, incl. NOP, gets a response exactly one cycle
//    later (NOP: from_peripheral_valid=1, code 01, data 0). Back-to-back commands -> back-to-back
//    pulses. Without a command, from_peripheral_valid=0, code 00, data 0.
//  - Responder FSM: IDLE -> RESP on valid command (registered code+data); RESP -> RESP on next
//    command else IDLE. Only state visible on ports is the response register.
//  - WRITE: if tx_count<FIFO_DEPTH at command cycle (before same-cycle drain) push, resp 01 data 0;
//    else drop word, set sticky tx_overflow, resp 11 data 0. Full+drain same cycle => still rejected.
//  - READ: if rx_count>0 pop head, resp 01 data=head; else resp 10 data 0. Empty+host push same
//    cycle => EMPTY (new word visible next cycle).
//  - STATUS: data = {zeros, tx_overflow[16], rx_count[15:8], tx_count[7:0]}, counts sampled
//    before same-cycle pushes/pops; resp 01; clears tx_overflow on the same edge (a WRITE overflow
//    cannot coincide, one command per cycle).
//  - FIFOs: circular buffers, pointers wrap modulo FIFO_DEPTH, count width log2(FIFO_DEPTH)+1,
//    zero-extended into 8-bit status fields. Simultaneous push+pop on one FIFO: count unchanged,
//    both succeed (push requires not-full before the pop).
//  - TX: out_data = head (first-word fall-through), out_valid = tx_count!=0; pop on out_valid&out_ready.
//  - RX: host_ready = rx_count!=FIFO_DEPTH; push on host_valid&host_ready; host_data held otherwise.
// CONFIGURATION
//  IO_LOOPBACK_EN defined: accepted WRITE words are pushed into the RX FIFO as well as TX (TX
//    fullness alone decides accept; if RX full, the RX copy is dropped silently); host_ready tied 0,
//    host_valid/host_data ignored.
//  Undefined (default): RX fed only by host port as above; no path from TX to RX.
// TESTING
//  1 reset low mid-traffic -> all outputs 0 next edge; after release STATUS returns 32'h0.
//  2 WRITE 32'hDEADBEEF, out_ready=0 -> next cycle resp 01; out_valid=1, out_data=32'hDEADBEEF;
//    STATUS -> 32'h00000001.
//  3 9 WRITEs (FIFO_DEPTH=8), out_ready=0 -> 8x resp 01, 9th resp 11; STATUS -> 32'h00010008;
//    2nd STATUS -> 32'h00000008.
//  4 READ on empty -> resp 10 data 0; host pushes 32'h0000000F, then READ -> resp 01 data 32'h0F.
//  5 RX full: host_ready=0; READ + host push same cycle -> push blocked, resp 01 with oldest word.
//  6 IO_LOOPBACK_EN: WRITE 32'h12345678 then READ -> resp 01 data 32'h12345678; host_ready stays 0.

Source files
------------

// File: rtl/peripheral_io_responder.sv
// Device end of the core's to_peripheral/from_peripheral port: TX FIFO to host, RX FIFO from host, status.
// Optional build macro IO_LOOPBACK_EN feeds accepted WRITE words into the RX FIFO instead of the host port.
module peripheral_io_responder #(
    parameter int DATA_WIDTH = 32,   // must be at least 17 to hold the status word
    parameter int FIFO_DEPTH = 8     // power of two, 2..128
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [1:0]            to_peripheral,
    input  logic [DATA_WIDTH-1:0] to_peripheral_data,
    input  logic                  to_peripheral_valid,
    output logic [1:0]            from_peripheral,
    output logic [DATA_WIDTH-1:0] from_peripheral_data,
    output logic                  from_peripheral_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    input  logic [DATA_WIDTH-1:0] host_data,
    input  logic                  host_valid,
    output logic                  host_ready
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic {IDLE, RESP} state_t;

    state_t                state_reg, state_next;
    logic [1:0]            code_reg, code_next;
    logic [DATA_WIDTH-1:0] data_reg, data_next;
    logic                  ovf_reg, ovf_next;

    logic [DATA_WIDTH-1:0] tx_mem [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] rx_mem [FIFO_DEPTH];
    logic [PW-1:0]         tx_wr_ptr_reg, tx_rd_ptr_reg, rx_wr_ptr_reg, rx_rd_ptr_reg;
    logic [CW-1:0]         tx_count_reg, rx_count_reg;

    logic                  tx_push, tx_pop, rx_push, rx_pop;
    logic                  tx_full, rx_empty, rx_full;
    logic [DATA_WIDTH-1:0] rx_push_data;
    logic [DATA_WIDTH-1:0] status_word;

    assign tx_full  = (tx_count_reg == DEPTH_C);
    assign rx_full  = (rx_count_reg == DEPTH_C);
    assign rx_empty = (rx_count_reg == '0);

    assign out_valid = (tx_count_reg != '0);
    assign out_data  = out_valid ? tx_mem[tx_rd_ptr_reg] : '0;
    assign tx_pop    = out_valid & out_ready;

`ifdef IO_LOOPBACK_EN
    // RX copy is best effort: TX fullness alone decides whether the WRITE is accepted.
    assign host_ready   = 1'b0;
    assign rx_push      = tx_push & ~rx_full;
    assign rx_push_data = to_peripheral_data;
`else
    logic ready_reg;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) ready_reg <= 1'b0;
        else        ready_reg <= 1'b1;
    end

    assign host_ready   = ready_reg & ~rx_full;
    assign rx_push      = host_valid & host_ready;
    assign rx_push_data = host_data;
`endif

    always_comb begin
        status_word        = '0;
        status_word[16]    = ovf_reg;
        status_word[15:8]  = 8'(rx_count_reg);
        status_word[7:0]   = 8'(tx_count_reg);
    end

    always_comb begin
        state_next = IDLE;
        code_next  = 2'b00;
        data_next  = '0;
        ovf_next   = ovf_reg;
        tx_push    = 1'b0;
        rx_pop     = 1'b0;
        case (state_reg)
            IDLE:    state_next = to_peripheral_valid ? RESP : IDLE;
            RESP:    state_next = to_peripheral_valid ? RESP : IDLE;
            default: state_next = IDLE;
        endcase
        if (to_peripheral_valid) begin
            code_next = 2'b01;
            case (to_peripheral)
                2'b01: begin
                    if (!tx_full) tx_push = 1'b1;
                    else begin
                        ovf_next  = 1'b1;
                        code_next = 2'b11;
                    end
                end
                2'b10: begin
                    if (!rx_empty) begin
                        rx_pop    = 1'b1;
                        data_next = rx_mem[rx_rd_ptr_reg];
                    end else begin
                        code_next = 2'b10;
                    end
                end
                2'b11: begin
                    data_next = status_word;
                    ovf_next  = 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            code_reg      <= 2'b00;
            data_reg      <= '0;
            ovf_reg       <= 1'b0;
            tx_wr_ptr_reg <= '0;
            tx_rd_ptr_reg <= '0;
            tx_count_reg  <= '0;
            rx_wr_ptr_reg <= '0;
            rx_rd_ptr_reg <= '0;
            rx_count_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            code_reg      <= code_next;
            data_reg      <= data_next;
            ovf_reg       <= ovf_next;
            if (tx_push) tx_wr_ptr_reg <= tx_wr_ptr_reg + PW'(1);
            if (tx_pop)  tx_rd_ptr_reg <= tx_rd_ptr_reg + PW'(1);
            if (rx_push) rx_wr_ptr_reg <= rx_wr_ptr_reg + PW'(1);
            if (rx_pop)  rx_rd_ptr_reg <= rx_rd_ptr_reg + PW'(1);
            tx_count_reg  <= tx_count_reg + CW'(tx_push) - CW'(tx_pop);
            rx_count_reg  <= rx_count_reg + CW'(rx_push) - CW'(rx_pop);
        end
    end

    // Storage carries no reset; stale entries are unreachable once the counts are cleared.
    always_ff @(posedge clock) begin
        if (tx_push) tx_mem[tx_wr_ptr_reg] <= to_peripheral_data;
        if (rx_push) rx_mem[rx_wr_ptr_reg] <= rx_push_data;
    end

    assign from_peripheral       = code_reg;
    assign from_peripheral_data  = data_reg;
    assign from_peripheral_valid = (state_reg == RESP);

endmodule
